hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the decode stage and its register file. A per-register pending-write

---
 rtl/hazard_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage pipeline sequencer.
//  - Per-register pending-write scoreboard stalls decode on RAW/WAW hazards.
//  - Taken branch/jump in EX flushes IF/ID and ID/EX, then keeps IF/ID
//    flushed for FLUSH_CYCLES more cycles to cover fetch latency.
//  - An outstanding D-mem access freezes the pipe until it is acknowledged.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cnt port,
// a 32-bit wrapping count of cycles with pc_stall asserted.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_r1,
    input  logic [4:0]  id_r2,
    input  logic        id_use_r1,
    input  logic        id_use_r2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_wr,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    output logic        pc_stall,
    output logic        id_bubble,
    output logic        ex_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int FCNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);
    localparam logic [FCNT_W-1:0] FCNT_ZERO   = {FCNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]    cnt_q [0:31];
    logic [CNT_W-1:0]    cnt_d [0:31];

    logic hazard_s;
    logic issue_s;
    logic inc_s;
    logic dec_s;

    // Hazard is taken from registered pending counts only: no WB bypass.
    assign hazard_s = id_valid &
                      ((id_use_r1 & (id_r1 != 5'd0) & (cnt_q[id_r1] != CNT_ZERO)) |
                       (id_use_r2 & (id_r2 != 5'd0) & (cnt_q[id_r2] != CNT_ZERO)) |
                       (id_reg_wr & (id_rd != 5'd0) & (cnt_q[id_rd] == CNT_MAX)));

    assign issue_s = id_valid & (state_q == ST_RUN) & ~hazard_s & ~ex_redirect & ~ex_hold;
    assign inc_s   = issue_s & id_reg_wr & (id_rd != 5'd0);
    assign dec_s   = wb_we & (wb_rd != 5'd0);

    // State register: FSM state and remaining flush cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= FCNT_ZERO;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic: memory wait outranks redirect; redirect reloads the flush window.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req & ~mem_ack) begin
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    state_d = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (~mem_ack) begin
                    state_d = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    // EX is released on the ack cycle, so a held redirect is taken now.
                    state_d = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (ex_redirect) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end else if (fcnt_q == FCNT_ONE) begin
                    state_d = ST_RUN;
                    fcnt_d  = FCNT_ZERO;
                end else begin
                    state_d = ST_FLUSH;
                    fcnt_d  = fcnt_q - FCNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = FCNT_ZERO;
            end
        endcase
    end

    // Output logic: same-cycle hold/flush/bubble controls, forced low while in reset.
    always_comb begin
        pc_stall    = 1'b0;
        id_bubble   = 1'b0;
        ex_hold     = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst) begin
            pc_stall = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_req & ~mem_ack) begin
                        ex_hold  = 1'b1;
                        pc_stall = 1'b1;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (hazard_s) begin
                        pc_stall  = 1'b1;
                        id_bubble = 1'b1;
                    end else begin
                        pc_stall = 1'b0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (~mem_ack) begin
                        ex_hold  = 1'b1;
                        pc_stall = 1'b1;
                    end else if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        ex_hold = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                    if (ex_redirect) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        id_ex_flush = 1'b0;
                    end
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    // Scoreboard next counts: issue increments rd, retire decrements wb_rd, both cancel.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        cnt_d[0] = CNT_ZERO;
        for (int i = 1; i < 32; i++) begin
            if ((inc_s & (id_rd == 5'(i))) & ~(dec_s & (wb_rd == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if ((dec_s & (wb_rd == 5'(i))) & ~(inc_s & (id_rd == 5'(i))) &
                         (cnt_q[i] != CNT_ZERO)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Scoreboard registers: pending-write count per architectural register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Performance counter: cycles spent with the PC held, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
        end else if (pc_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// constrained-random traffic, all compared against a behavioural model.
module tb_hazard_ctrl;

    localparam int FC   = 2;   // flush window after a redirect
    localparam int MAXC = 3;   // max pending writes per register

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_r1 = 5'd0, id_r2 = 5'd0, id_rd = 5'd0, wb_rd = 5'd0;
    logic        id_use_r1 = 1'b0, id_use_r2 = 1'b0, id_reg_wr = 1'b0;
    logic        ex_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0, wb_we = 1'b0;
    logic        pc_stall, id_bubble, ex_hold, if_id_flush, id_ex_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_use_r1(id_use_r1), .id_use_r2(id_use_r2),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
        .wb_we(wb_we), .wb_rd(wb_rd),
        .pc_stall(pc_stall), .id_bubble(id_bubble), .ex_hold(ex_hold),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pending writes per register, pipeline mode, flush cycles left.
    int pend [32];
    int mode;          // 0 = running, 1 = waiting on memory, 2 = flushing
    int flush_left;
    int unsigned stalls;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        mode = 0;
        flush_left = 0;
        stalls = 0;
    endtask

    task automatic drv(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit redir, input bit mreq,
                       input bit mack, input bit we, input int wrd);
        id_valid = v; id_r1 = 5'(r1); id_use_r1 = u1; id_r2 = 5'(r2); id_use_r2 = u2;
        id_rd = 5'(rd); id_reg_wr = wr; ex_redirect = redir; mem_req = mreq;
        mem_ack = mack; wb_we = we; wb_rd = 5'(wrd);
    endtask

    // Called at a negedge with inputs driven; checks outputs, then advances one clock.
    task automatic step();
        bit hz, mem_block, redir_taken, issue, e_stall, e_bub, e_iff, e_ief;
        bit wr_hit, rt_hit;
        #1;
        hz = id_valid && ((id_use_r1 && id_r1 != 0 && pend[id_r1] > 0) ||
                          (id_use_r2 && id_r2 != 0 && pend[id_r2] > 0) ||
                          (id_reg_wr && id_rd != 0 && pend[id_rd] >= MAXC));
        mem_block   = (mode == 0 && mem_req && !mem_ack) || (mode == 1 && !mem_ack);
        redir_taken = ex_redirect && !mem_block;
        e_bub       = (mode == 0) && !mem_block && !ex_redirect && hz;
        e_stall     = mem_block || e_bub;
        e_iff       = redir_taken || (mode == 2);
        e_ief       = redir_taken;
        issue       = id_valid && mode == 0 && !mem_block && !ex_redirect && !hz;
        check_val("ex_hold", {31'd0, ex_hold}, {31'd0, mem_block});
        check_val("pc_stall", {31'd0, pc_stall}, {31'd0, e_stall});
        check_val("id_bubble", {31'd0, id_bubble}, {31'd0, e_bub});
        check_val("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_iff});
        check_val("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_ief});
`ifdef HAZARD_PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, stalls);
`endif
        @(posedge clk);
        if (e_stall) stalls++;
        wr_hit = issue && id_reg_wr && id_rd != 0;
        rt_hit = wb_we && wb_rd != 0;
        if (wr_hit && rt_hit && id_rd == wb_rd) begin
            // writer and retire on the same register cancel out
        end else begin
            if (wr_hit) pend[id_rd]++;
            if (rt_hit && pend[wb_rd] > 0) pend[wb_rd]--;
        end
        if (mem_block) mode = 1;
        else if (redir_taken) begin mode = 2; flush_left = FC; end
        else if (mode == 2) begin
            flush_left--;
            if (flush_left == 0) mode = 0;
        end
        else mode = 0;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        check_val("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
        check_val("rst_flush", {30'd0, if_id_flush, id_ex_flush}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // RAW on x5: reader stalls until the retire, issues the cycle after.
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); step();
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0); #1;
        check_val("raw_bubble", {31'd0, id_bubble}, 32'd1);
        step(); step();
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 5); #1;
        check_val("raw_no_bypass", {31'd0, id_bubble}, 32'd1);
        step();
        drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0); #1;
        check_val("raw_issue", {31'd0, id_bubble}, 32'd0);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6); step();

        // WAW saturation on x7.
        for (int k = 0; k < 3; k++) begin
            drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); step();
        end
        #1; check_val("waw_full_stall", {31'd0, pc_stall}, 32'd1);
        step();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 7); #1;
        check_val("waw_retire_cycle", {31'd0, pc_stall}, 32'd1);
        step();
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0); #1;
        check_val("waw_release", {31'd0, pc_stall}, 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7); step();
        end

        // Issue and retire of x9 in the same cycle leave its count at 1.
        drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 9); step();
        drv(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("same_cycle_reader", {31'd0, id_bubble}, 32'd1);
        step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9); step();

        // Redirect: both flushed at cycle 0, IF/ID flushed cycles 1-2, running at 3.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
        check_val("redir_c0", {30'd0, if_id_flush, id_ex_flush}, 32'd3);
        step();
        idle(); #1; check_val("redir_c1", {30'd0, if_id_flush, id_ex_flush}, 32'd2); step();
        #1; check_val("redir_c2", {30'd0, if_id_flush, id_ex_flush}, 32'd2); step();
        #1; check_val("redir_c3", {30'd0, if_id_flush, id_ex_flush}, 32'd0); step();

        // Memory wait of 4 cycles with a redirect held by EX throughout.
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 0, 0, 0, 0, 0, 1, 1, (k == 3), 0, 0); #1;
            check_val("mem_hold", {31'd0, ex_hold}, (k == 3) ? 32'd0 : 32'd1);
            check_val("mem_redir", {31'd0, id_ex_flush}, (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        idle(); step(); step();

        // Asynchronous reset in the middle of a memory wait with x3 pending twice.
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0); step(); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
        #3; rst = 1'b0; #1;
        check_val("rst_mid_hold", {27'd0, pc_stall, id_bubble, ex_hold, if_id_flush, id_ex_flush}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_val("rst_mid_cnt", stall_cnt, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_val("rst_cnt_clear", {31'd0, id_bubble}, 32'd0);
        step();

        // Constrained-random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit v, u1, u2, wr, rd_ok, mreq, mack, we;
            int r1, r2, rd, wrd;
            v  = ($urandom_range(0, 9) < 7);
            r1 = $urandom_range(0, 7); r2 = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1); wr = ($urandom_range(0, 3) != 0);
            if (mode == 1) begin mreq = 1; mack = ($urandom_range(0, 2) == 0); end
            else if (mode == 0) begin mreq = ($urandom_range(0, 9) == 0); mack = $urandom_range(0, 1); end
            else begin mreq = 0; mack = 0; end
            we  = ($urandom_range(0, 9) < 4);
            wrd = $urandom_range(0, 7);
            rd_ok = 0;
            for (int t = 0; t < 4 && !rd_ok && $urandom_range(0, 9) < 8; t++) begin
                int c;
                c = $urandom_range(1, 7);
                if (pend[c] > 0) begin wrd = c; rd_ok = 1; end
            end
            drv(v, r1, u1, r2, u2, rd, wr, ($urandom_range(0, 19) == 0), mreq, mack, we, wrd);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
